// File: rtl/ddr_port_arbiter_if.sv
// Client and DDR-controller signal bundle for ddr_port_arbiter.
// The master modport is the arbiter; the slave modport is the clients plus controller.
interface ddr_port_arbiter_if #(
  parameter int NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0]    ClReq;
  logic [NUM_CLIENTS-1:0]    ClWr;
  logic [2*NUM_CLIENTS-1:0]  ClBank;
  logic [23*NUM_CLIENTS-1:0] ClAddr;
  logic [16*NUM_CLIENTS-1:0] ClWData;
  logic [NUM_CLIENTS-1:0]    ClAck;
  logic [NUM_CLIENTS-1:0]    ClDone;
  logic [NUM_CLIENTS-1:0]    ClErr;
  logic [15:0]               ClRData;
  logic                      WrStart;
  logic                      RdStart;
  logic [1:0]                WrBank;
  logic [1:0]                RdBank;
  logic [22:0]               WrAddr;
  logic [22:0]               RdAddr;
  logic [15:0]               WrData;
  logic                      WrReady;
  logic                      RdReady;
  logic [15:0]               RdData;
  logic                      DevReady;
  logic                      Fault;

  modport master (
    input  ClReq, ClWr, ClBank, ClAddr, ClWData, WrReady, RdReady, RdData, DevReady,
    output ClAck, ClDone, ClErr, ClRData, WrStart, RdStart, WrBank, RdBank,
           WrAddr, RdAddr, WrData, Fault
  );

  modport slave (
    output ClReq, ClWr, ClBank, ClAddr, ClWData, WrReady, RdReady, RdData, DevReady,
    input  ClAck, ClDone, ClErr, ClRData, WrStart, RdStart, WrBank, RdBank,
           WrAddr, RdAddr, WrData, Fault
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter serialising client read/write transactions onto one DDR
// controller port, with per-wait-state timeout and sticky fault reporting.
module ddr_port_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic              CLK_200MHz,
  input  logic              RST,
  ddr_port_arbiter_if.master bus
);
  localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_t;

  state_t          state;
  logic [GW-1:0]   last;
  logic [GW-1:0]   gnt;
  logic            wr_dir;
  logic [15:0]     cnt;
  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic            sel_ready;

  function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [GW-1:0] idx);
    return NUM_CLIENTS'(1) << idx;
  endfunction

  // Search from the client after the last owner; requesters whose path is busy are skipped.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      cand = GW'((int'(last) + off) % NUM_CLIENTS);
      if (!found && bus.ClReq[cand] && (bus.ClWr[cand] ? bus.WrReady : bus.RdReady)) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel_ready = wr_dir ? bus.WrReady : bus.RdReady;

  always_ff @(posedge CLK_200MHz or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      last        <= GW'(NUM_CLIENTS - 1);
      gnt         <= '0;
      wr_dir      <= 1'b0;
      cnt         <= '0;
      bus.ClAck   <= '0;
      bus.ClDone  <= '0;
      bus.ClErr   <= '0;
      bus.ClRData <= '0;
      bus.WrStart <= 1'b0;
      bus.RdStart <= 1'b0;
      bus.WrBank  <= '0;
      bus.RdBank  <= '0;
      bus.WrAddr  <= '0;
      bus.RdAddr  <= '0;
      bus.WrData  <= '0;
      bus.Fault   <= 1'b0;
    end else begin
      bus.ClAck   <= '0;
      bus.ClDone  <= '0;
      bus.ClErr   <= '0;
      bus.WrStart <= 1'b0;
      bus.RdStart <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.DevReady && found) begin
            gnt       <= pick;
            wr_dir    <= bus.ClWr[pick];
            bus.ClAck <= onehot(pick);
            if (bus.ClWr[pick]) begin
              bus.WrStart <= 1'b1;
              bus.WrBank  <= bus.ClBank[2*int'(pick) +: 2];
              bus.WrAddr  <= bus.ClAddr[23*int'(pick) +: 23];
              bus.WrData  <= bus.ClWData[16*int'(pick) +: 16];
            end else begin
              bus.RdStart <= 1'b1;
              bus.RdBank  <= bus.ClBank[2*int'(pick) +: 2];
              bus.RdAddr  <= bus.ClAddr[23*int'(pick) +: 23];
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_ACCEPT;
        end
        WAIT_ACCEPT: begin
          if (!sel_ready) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            bus.ClDone <= onehot(gnt);
            bus.ClErr  <= onehot(gnt);
            bus.Fault  <= 1'b1;
            last       <= gnt;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          // Completion is checked before the limit so a late Ready still succeeds.
          if (sel_ready) begin
            bus.ClDone <= onehot(gnt);
            if (!wr_dir) bus.ClRData <= bus.RdData;
            last  <= gnt;
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            bus.ClDone <= onehot(gnt);
            bus.ClErr  <= onehot(gnt);
            bus.Fault  <= 1'b1;
            last       <= gnt;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
